regfile_demux_wb: RTL and testbench

- 32 x 64-bit register file for the LEGv8 datapath.
- The single write-back value is routed to exactly one register by a 5:32 write-enable demultiplexer. This is the write-side counterpart of the 64-bit 2:1 data selectors on the read and ALU-source paths.
- Two combinational read ports feed the ALU operand selectors.
- X31 (XZR) is hardwired to zero.
- Sits between the write-back selector (MemToReg mux output) and the decode stage.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_demux_wb_decoder.sv | 39 +++
 rtl/regfile_demux_wb.sv | 77 +++++++
 tb/tb_regfile_demux_wb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the LEGv8 register file.
// X31 reads as zero and cannot be written.
package regfile_pkg;

  localparam int WIDTH = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [AW-1:0] XZR_IDX = 5'd31;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [AW-1:0]    regidx_t;

  // 64-bit 2:1 data selector; the read trees are built from this primitive.
  function automatic word_t mux2(input logic s, input word_t a0, input word_t a1);
    return s ? a1 : a0;
  endfunction

endpackage

// File: rtl/regfile_demux_wb_decoder.sv
// Gate-level 5:32 one-hot decoder assembled from a 2:4 stage and four 3:8 stages.
// With en=0 every output is 0, even when idx is unknown.
module dec2_4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);
  assign y[0] = en & ~a[1] & ~a[0];
  assign y[1] = en & ~a[1] &  a[0];
  assign y[2] = en &  a[1] & ~a[0];
  assign y[3] = en &  a[1] &  a[0];
endmodule

module dec3_8 (
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y
);
  logic [3:0] lo;

  // a[2] splits the enable, a[1:0] picks within each half
  dec2_4 u_lo (.en(en & ~a[2]), .a(a[1:0]), .y(lo));
  dec2_4 u_hi (.en(en &  a[2]), .a(a[1:0]), .y(y[7:4]));
  assign y[3:0] = lo;
endmodule

module decoder5_32 (
  input  logic        en,
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);
  logic [3:0] grp;

  dec2_4 u_grp (.en(en), .a(idx[4:3]), .y(grp));

  for (genvar g = 0; g < 4; g++) begin : g_oct
    dec3_8 u_oct (.en(grp[g]), .a(idx[2:0]), .y(onehot[8*g +: 8]));
  end
endmodule

// File: rtl/regfile_demux_wb.sv
// 32 x 64-bit LEGv8 register file: one demuxed write port, two combinational
// read ports with same-cycle write bypass, X31 hardwired to zero.
module regfile_demux_wb
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [NREGS-1:0] dec;
  logic             wr_live;
  word_t            rf [NREGS];
  regidx_t          ridx [2];
  word_t            rdata [2];

  // RegWrite gates the decoder, so an unknown index cannot raise an enable
  decoder5_32 u_dec (
    .en     (RegWrite),
    .idx    (WriteRegister),
    .onehot (dec)
  );

  // A live write never targets XZR and is suppressed while in reset
  assign wr_live = reset & RegWrite & ~dec[XZR_IDX];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == int'(XZR_IDX)) begin : g_zr
      assign rf[i] = '0;
    end else begin : g_q
      word_t q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)      q <= '0;
        else if (dec[i]) q <= WriteData;
      end
      assign rf[i] = q;
    end
  end

  assign ridx[0] = ReadRegister1;
  assign ridx[1] = ReadRegister2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    word_t s0 [16];
    word_t s1 [8];
    word_t s2 [4];
    word_t s3 [2];
    word_t sel;

    for (genvar j = 0; j < 16; j++) begin : g_l0
      assign s0[j] = mux2(ridx[p][0], rf[2*j], rf[2*j+1]);
    end
    for (genvar j = 0; j < 8; j++) begin : g_l1
      assign s1[j] = mux2(ridx[p][1], s0[2*j], s0[2*j+1]);
    end
    for (genvar j = 0; j < 4; j++) begin : g_l2
      assign s2[j] = mux2(ridx[p][2], s1[2*j], s1[2*j+1]);
    end
    for (genvar j = 0; j < 2; j++) begin : g_l3
      assign s3[j] = mux2(ridx[p][3], s2[2*j], s2[2*j+1]);
    end
    assign sel = mux2(ridx[p][4], s3[0], s3[1]);

    // Bypass forwards the in-flight write so a same-cycle read sees it
    assign rdata[p] = mux2(wr_live && (ridx[p] == WriteRegister), sel, WriteData);
  end

  assign ReadData1 = rdata[0];
  assign ReadData2 = rdata[1];

endmodule

// File: tb/tb_regfile_demux_wb.sv
// Directed bench for regfile_demux_wb with a reference model and an expectation queue.
module tb_regfile_demux_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int checks = 0;
  int failures = 0;

  logic [63:0] model [32];

  typedef struct {
    string       tag;
    int          port;
    logic [63:0] exp;
  } exp_t;
  exp_t sbq[$];

  regfile_demux_wb dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mread(input int idx);
    return (idx == 31) ? 64'h0 : model[idx];
  endfunction

  task automatic push(input string tag, input int port, input logic [63:0] e);
    exp_t x;
    x.tag = tag;
    x.port = port;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [63:0] obs;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      obs = (x.port == 1) ? ReadData1 : ReadData2;
      checks++;
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s port%0d observed=%h expected=%h", x.tag, x.port, obs, x.exp);
      end
    end
  endtask

  // Set both read indices, let the combinational path settle, compare.
  task automatic rd(input int a, input int b, input string tag,
                    input logic [63:0] e1, input logic [63:0] e2);
    ReadRegister1 = 5'(a);
    ReadRegister2 = 5'(b);
    #1;
    push(tag, 1, e1);
    push(tag, 2, e2);
    drain();
  endtask

  task automatic wr(input int idx, input logic [63:0] d);
    RegWrite = 1'b1;
    WriteRegister = 5'(idx);
    WriteData = d;
    tick();
    if (idx != 31) model[idx] = d;
    RegWrite = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) rd(i, 31 - i, tag, mread(i), mread(31 - i));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    reset = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = 5'd0;
    WriteData = 64'h0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    #2;
    rd(0, 5, "reset_state", 64'h0, 64'h0);
    #5 reset = 1'b1;
    tick();

    // Reset mid-cycle clears without a clock edge; pending write and bypass suppressed
    wr(5, 64'hDEAD_BEEF_0000_0001);
    rd(5, 0, "pre_reset_x5", 64'hDEAD_BEEF_0000_0001, 64'h0);
    RegWrite = 1'b1;
    WriteRegister = 5'd5;
    WriteData = 64'hCAFE_0000_0000_0005;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    rd(5, 5, "async_reset", 64'h0, 64'h0);
    tick();
    rd(5, 6, "reset_write_ignored", 64'h0, 64'h0);
    RegWrite = 1'b0;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 31; i++) wr(i, 64'h0123456789ABCDEF ^ 64'(i));
    sweep("write_sweep");

    // XZR write discarded, never bypassed
    RegWrite = 1'b1;
    WriteRegister = 5'd31;
    WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    rd(31, 31, "xzr_no_bypass", 64'h0, 64'h0);
    tick();
    RegWrite = 1'b0;
    sweep("xzr_after");

    // Bypass before and after the edge
    wr(7, 64'hAAAA);
    RegWrite = 1'b1;
    WriteRegister = 5'd7;
    WriteData = 64'h5555;
    rd(7, 7, "bypass_pre", 64'h5555, 64'h5555);
    rd(7, 6, "bypass_one_port", 64'h5555, mread(6));
    tick();
    model[7] = 64'h5555;
    RegWrite = 1'b0;
    rd(7, 7, "bypass_post", 64'h5555, 64'h5555);

    // Write disabled: no update, no bypass
    RegWrite = 1'b0;
    WriteRegister = 5'd3;
    WriteData = 64'h1234;
    rd(3, 3, "wdis_pre", mread(3), mread(3));
    tick();
    rd(3, 3, "wdis_post", mread(3), mread(3));

    // Unknown index with RegWrite low leaves state intact
    WriteRegister = 5'bxxxxx;
    WriteData = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    WriteRegister = 5'd0;
    sweep("x_index");

    // Port independence
    wr(1, 64'h11);
    wr(2, 64'h22);
    rd(1, 2, "dual_straight", 64'h11, 64'h22);
    rd(2, 1, "dual_swapped", 64'h22, 64'h11);
    rd(30, 30, "dual_same", mread(30), mread(30));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
